// File: rtl/batpu_pkg.sv
// Shared datapath constants and types for the BATPU core (ALU, decoder, register file).
package batpu_pkg;

    localparam int DATA_W = 8;
    localparam int NREGS  = 16;
    localparam int ADDR_W = $clog2(NREGS);

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

endpackage : batpu_pkg

// File: rtl/regfile_wb.sv
// Register file with a one-deep write-back stage that forwards to both read ports,
// plus the carry/zero flag registers. r0 is hard-wired to zero.
module regfile_wb #(
    parameter int   DATA_W = batpu_pkg::DATA_W,
    parameter int   NREGS  = batpu_pkg::NREGS,
    localparam int  ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flag_we,
    input  logic              alu_cout,
    input  logic              alu_zero,
    output logic              flag_c,
    output logic              flag_z
);

    logic [DATA_W-1:0] regs_r [NREGS];
    logic              s_valid_r;
    logic [ADDR_W-1:0] s_dest_r;
    logic [DATA_W-1:0] s_data_r;

    // Write-back stage capture and commit of the previous stage entry into the array.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_valid_r <= 1'b0;
            s_dest_r  <= {ADDR_W{1'b0}};
            s_data_r  <= {DATA_W{1'b0}};
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            // Writes to r0 never enter the stage, so the array entry for r0 is never touched.
            s_valid_r <= wb_valid && (wb_dest != {ADDR_W{1'b0}});
            if (wb_valid && (wb_dest != {ADDR_W{1'b0}})) begin
                s_dest_r <= wb_dest;
                s_data_r <= wb_data;
            end else begin
                s_dest_r <= s_dest_r;
                s_data_r <= s_data_r;
            end
            if (s_valid_r) begin
                regs_r[s_dest_r] <= s_data_r;
            end else begin
                regs_r[s_dest_r] <= regs_r[s_dest_r];
            end
        end
    end

    // Flag registers, loaded regardless of the write-back destination.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else if (flag_we) begin
            flag_c <= alu_cout;
            flag_z <= alu_zero;
        end else begin
            flag_c <= flag_c;
            flag_z <= flag_z;
        end
    end

    // Port a read: stage forwarding only, never from wb_data, to keep the ALU loop open.
    always_comb begin
        rd_data_a = regs_r[rd_addr_a];
        if (rd_addr_a == {ADDR_W{1'b0}}) begin
            rd_data_a = {DATA_W{1'b0}};
        end else if (s_valid_r && (s_dest_r == rd_addr_a)) begin
            rd_data_a = s_data_r;
        end else begin
            rd_data_a = regs_r[rd_addr_a];
        end
    end

    // Port b read, identical to port a.
    always_comb begin
        rd_data_b = regs_r[rd_addr_b];
        if (rd_addr_b == {ADDR_W{1'b0}}) begin
            rd_data_b = {DATA_W{1'b0}};
        end else if (s_valid_r && (s_dest_r == rd_addr_b)) begin
            rd_data_b = s_data_r;
        end else begin
            rd_data_b = regs_r[rd_addr_b];
        end
    end

endmodule : regfile_wb
